// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the Booth multiplier sequencer.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_START = 2'd1,
    SEQ_RUN   = 2'd2,
    SEQ_CLEAR = 2'd3
  } seq_state_t;

  // Cycles from op_start to op_done in the multiplier core.
  localparam int MUL_CORE_LATENCY = 65;

  localparam int DEF_WIDTH       = 64;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TIMEOUT_CYC = 80;

  // Counter width able to hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Bus bundle between the sequencer, its operand producer, its product
// consumer and the multiplier core. master = sequencer side.
interface mul_seq_if
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  // operand stream
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   in_multiplier;
  logic signed [WIDTH-1:0]   in_multiplicand;
  // multiplier core
  logic signed [WIDTH-1:0]   mul_multiplier;
  logic signed [WIDTH-1:0]   mul_multiplicand;
  logic                      mul_op_start;
  logic                      mul_op_clear;
  logic                      mul_op_done;
  logic signed [2*WIDTH-1:0] mul_result;
  // product stream
  logic                      out_valid;
  logic                      out_ready;
  logic signed [2*WIDTH-1:0] out_result;

  modport master (
    input  in_valid, in_multiplier, in_multiplicand,
    output in_ready,
    output mul_multiplier, mul_multiplicand, mul_op_start, mul_op_clear,
    input  mul_op_done, mul_result,
    output out_valid, out_result,
    input  out_ready
  );

  modport slave (
    output in_valid, in_multiplier, in_multiplicand,
    input  in_ready,
    input  mul_multiplier, mul_multiplicand, mul_op_start, mul_op_clear,
    output mul_op_done, mul_result,
    input  out_valid, out_result,
    output out_ready
  );

endinterface

// File: rtl/mul_seq_fifo.sv
// Synchronous operand-pair FIFO with full/empty flags, same-cycle push/pop
// and a synchronous flush. Storage is not reset; only the pointers are.
module mul_seq_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/mul_sequencer.sv
// Front/back-end controller for the radix-2 Booth multiplier core.
// Queues operand pairs, runs the core's op_start/op_clear handshake and
// captures each product into a valid/ready output register.
// Optional watchdog: define MUL_SEQ_TIMEOUT_EN to add err_timeout.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     flush,
  output logic     busy,
`ifdef MUL_SEQ_TIMEOUT_EN
  output logic     err_timeout,
`endif
  mul_seq_if.master bus
);

  seq_state_t              r_state;
  seq_state_t              w_state_nxt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_capture;
  logic [2*WIDTH-1:0]      w_head;
  logic                    r_op_start;
  logic                    r_op_clear;
  logic                    r_out_valid;
  logic signed [2*WIDTH-1:0] r_out_result;
  logic signed [WIDTH-1:0] r_mul_a;
  logic signed [WIDTH-1:0] r_mul_b;

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_timeout;
`endif

  // An operand pair offered during flush is discarded.
  assign w_push = bus.in_valid && !w_full && !flush;

  mul_seq_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  ({bus.in_multiplier, bus.in_multiplicand}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state decode; capture only when the output register is free.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_pop       = 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      SEQ_IDLE: begin
        if (!w_empty && !flush) w_state_nxt = SEQ_START;
      end
      SEQ_START: begin
        w_state_nxt = flush ? SEQ_CLEAR : SEQ_RUN;
      end
      SEQ_RUN: begin
        if (flush) begin
          w_state_nxt = SEQ_CLEAR;
        end else if (bus.mul_op_done && (!r_out_valid || bus.out_ready)) begin
          w_capture   = 1'b1;
          w_state_nxt = SEQ_CLEAR;
        end
`ifdef MUL_SEQ_TIMEOUT_EN
        else if (!bus.mul_op_done && (r_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
          w_timeout   = 1'b1;
          w_state_nxt = SEQ_CLEAR;
        end
`endif
      end
      SEQ_CLEAR: begin
        // After a flush the FIFO is already empty, so this pop is a no-op.
        w_pop       = 1'b1;
        w_state_nxt = SEQ_IDLE;
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  // State register plus registered core strobes, so op_clear never
  // follows op_done combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SEQ_IDLE;
      r_op_start <= 1'b0;
      r_op_clear <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_start <= (w_state_nxt == SEQ_START);
      r_op_clear <= (w_state_nxt == SEQ_CLEAR);
    end
  end

  // Latch the FIFO head on the way into START; held until the next op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (w_state_nxt == SEQ_START) begin
      {r_mul_a, r_mul_b} <= w_head;
    end
  end

  // Product output register: load on capture, drop valid on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= bus.mul_result;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

`ifdef MUL_SEQ_TIMEOUT_EN
  // Watchdog: count RUN cycles from START, sticky error on expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_state_nxt == SEQ_START) r_cnt <= '0;
      else if (r_state == SEQ_RUN)  r_cnt <= r_cnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err_timeout = r_err;
`endif

  assign bus.in_ready         = !w_full;
  assign bus.mul_multiplier   = r_mul_a;
  assign bus.mul_multiplicand = r_mul_b;
  assign bus.mul_op_start     = r_op_start;
  assign bus.mul_op_clear     = r_op_clear;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_result       = r_out_result;
  assign busy                 = (r_state != SEQ_IDLE) || !w_empty;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer with a behavioural multiplier core.
module tb_mul_sequencer;
  import mul_seq_pkg::*;

  localparam int W  = 64;
  localparam int TO = 80;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
`ifdef MUL_SEQ_TIMEOUT_EN
  logic err_timeout;
`endif

  mul_seq_if #(.WIDTH(W)) bus();

  mul_sequencer #(
    .WIDTH       (W),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .busy        (busy),
`ifdef MUL_SEQ_TIMEOUT_EN
    .err_timeout (err_timeout),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: op_done at start+65, held until op_clear.
  logic         core_run;
  int           core_cnt;
  logic [127:0] core_res;
  logic         stub = 1'b0;

  function automatic logic [127:0] smul(input logic signed [63:0] a, input logic signed [63:0] b);
    logic signed [127:0] x;
    logic signed [127:0] y;
    x = a;
    y = b;
    return x * y;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_run <= 1'b0;
      core_cnt <= 0;
      core_res <= '0;
    end else if (bus.mul_op_clear) begin
      core_run <= 1'b0;
      core_cnt <= 0;
    end else if (bus.mul_op_start) begin
      core_run <= 1'b1;
      core_cnt <= 1;
      core_res <= smul(bus.mul_multiplier, bus.mul_multiplicand);
    end else if (core_run && core_cnt < MUL_CORE_LATENCY) begin
      core_cnt <= core_cnt + 1;
    end
  end

  assign bus.mul_op_done = core_run && (core_cnt >= MUL_CORE_LATENCY) && !bus.mul_op_clear && !stub;
  assign bus.mul_result  = core_res;

  logic [127:0] sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, latency, start period, output stability.
  int           last_start = 0;
  int           n_starts = 0;
  bit           have_prev = 0;
  bit           chk_period = 0;
  bit           prev_valid = 0;
  bit           prev_hold = 0;
  logic [127:0] prev_result = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mul_op_start) begin
        if (chk_period && have_prev) check("start_period", cyc - last_start, 68);
        last_start = cyc;
        have_prev  = 1;
        n_starts++;
      end
      if (bus.out_valid && !prev_valid) check("valid_latency", cyc - last_start, 66);
      if (prev_hold && bus.out_valid) check("hold_stable", bus.out_result, prev_result);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h expected none", bus.out_result);
        end else begin
          check("result", bus.out_result, sb.pop_front());
        end
      end
      prev_valid  = bus.out_valid;
      prev_hold   = bus.out_valid && !bus.out_ready;
      prev_result = bus.out_result;
    end else begin
      prev_valid = 0;
      prev_hold  = 0;
    end
  end

  task automatic push(input logic signed [63:0] a, input logic signed [63:0] b,
                      input logic [127:0] exp, input bit track);
    bit ok;
    ok = 0;
    bus.in_valid        = 1'b1;
    bus.in_multiplier   = a;
    bus.in_multiplicand = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 expected accept");
    end else if (track) begin
      sb.push_back(exp);
    end
  endtask

  task automatic wait_started(input int s0);
    for (int i = 0; i < 300 && n_starts == s0; i++) begin
      @(negedge clk);
      #1;
    end
    if (n_starts == s0) begin
      total++;
      bad++;
      $display("FAIL start_timeout: got no op_start expected one");
    end
  endtask

  // Advance to the drive point of cycle (last op_start + k).
  task automatic goto_cycle(input int k);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (cyc >= last_start + k) break;
    end
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || bus.out_valid) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  int s0;
  int nclr;

  initial begin
    bus.in_valid        = 1'b0;
    bus.in_multiplier   = '0;
    bus.in_multiplicand = '0;
    bus.out_ready       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_op_start",  bus.mul_op_start, 0);
    check("rst_op_clear",  bus.mul_op_clear, 0);
    check("rst_busy",      busy, 0);
    check("rst_out_result", bus.out_result, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // basic product, operands held during the run
    s0 = n_starts;
    push(3, 5, 128'd15, 1);
    wait_started(s0);
    repeat (30) @(negedge clk);
    check("t1_mul_a", bus.mul_multiplier, 3);
    check("t1_mul_b", bus.mul_multiplicand, 5);
    check("t1_start_pulse", bus.mul_op_start, 0);
    wait_drain(400);

    // signed cases
    push(-2, 7, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF2, 1);
    push(64'h8000_0000_0000_0000, -1, 128'h0000_0000_0000_0000_8000_0000_0000_0000, 1);
    wait_drain(600);

    // fill the FIFO, back-to-back ops
    have_prev  = 0;
    chk_period = 1;
    push(2, 3, 128'd6, 1);
    push(-4, 5, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEC, 1);
    push(100, 100, 128'd10000, 1);
    push(7, -8, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC8, 1);
    check("t3_full_in_ready", bus.in_ready, 0);
    check("t3_busy", busy, 1);
    push(64'h1_0000_0000, 64'h1_0000_0000, 128'h0000_0000_0000_0001_0000_0000_0000_0000, 1);
    wait_drain(2000);
    chk_period = 0;

    // back-pressure across two ops
    bus.out_ready = 1'b0;
    push(9, 9, 128'd81, 1);
    push(-3, -3, 128'd9, 1);
    nclr = 0;
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      if (bus.mul_op_clear) nclr++;
    end
    check("t4_clear_count", nclr, 1);
    check("t4_core_done",   bus.mul_op_done, 1);
    check("t4_out_valid",   bus.out_valid, 1);
    check("t4_out_first",   bus.out_result, 128'd81);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain(200);

    // flush mid-run with two pairs queued
    s0 = n_starts;
    push(1, 2, '0, 0);
    push(3, 4, '0, 0);
    push(5, 6, '0, 0);
    wait_started(s0);
    goto_cycle(30);
    flush               = 1'b1;
    bus.in_valid        = 1'b1;
    bus.in_multiplier   = 64'sd7;
    bus.in_multiplicand = 64'sd7;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_op_clear", bus.mul_op_clear, 1);
    check("t5_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    check("t5_idle_empty", busy, 0);
    repeat (100) @(posedge clk);
    #1;
    check("t5_no_output", bus.out_valid, 0);
    check("t5_no_restart", n_starts, s0 + 1);

    // asynchronous reset mid-run
    s0 = n_starts;
    push(11, 13, '0, 0);
    wait_started(s0);
    goto_cycle(40);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_in_ready",   bus.in_ready, 1);
    check("t6_out_valid",  bus.out_valid, 0);
    check("t6_op_start",   bus.mul_op_start, 0);
    check("t6_op_clear",   bus.mul_op_clear, 0);
    check("t6_busy",       busy, 0);
    check("t6_mul_a",      bus.mul_multiplier, 0);
    check("t6_out_result", bus.out_result, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef MUL_SEQ_TIMEOUT_EN
    // watchdog with a core that never finishes
    stub = 1'b1;
    s0 = n_starts;
    push(4, 4, '0, 0);
    wait_started(s0);
    goto_cycle(TO);
    check("to_not_yet", err_timeout, 0);
    @(posedge clk);
    #1;
    check("to_err", err_timeout, 1);
    check("to_clear", bus.mul_op_clear, 1);
    @(posedge clk);
    #1;
    check("to_sticky", err_timeout, 1);
    check("to_idle", busy, 0);
    stub = 1'b0;
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
